fft_frame_ctrl: RTL and testbench

Input sequencer and frame tracker for the radix-2 pipelined FFT stage chain. Accepts complex samples over a valid/ready stream and groups them into frames of 2^N samples. Drives the first stage's enable pulse, sample index counter and data. Monitors the last stage's enable/count outputs to report frame completion, frames in flight and stream underrun.

---
 rtl/fft_frame_ctrl.sv | 163 ++++++++++++++++
 tb/tb_fft_frame_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl: input sequencer and frame tracker for a radix-2 pipelined
// FFT stage chain. Takes complex samples from a valid/ready stream and groups
// them into frames of 2^N samples. Drives the first stage with a registered
// enable pulse, sample index and data. Watches the last stage to report frame
// completion, frames in flight and stream underrun.
//
// Once a frame has started, the pipeline cannot stall. A missing input sample
// is replaced by a zero sample, and the sticky underrun flag is set. Dropping
// run never truncates a frame. It only stops the next frame from starting
// straight after the current one.
module fft_frame_ctrl #(
   parameter int width = 16,
   parameter int N     = 9,
   parameter int F     = 4
) (
   input  logic             clk,
   input  logic             areset,
   input  logic             run,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [width-1:0] s_re,
   input  logic [width-1:0] s_im,
   output logic             p_en,
   output logic [N-1:0]     p_cnt,
   output logic [width-1:0] p_re,
   output logic [width-1:0] p_im,
   input  logic             q_en,
   input  logic [N-1:0]     q_cnt,
   output logic             frame_done,
   output logic [F-1:0]     in_flight,
   output logic             busy,
   output logic             err_underrun,
   input  logic             clr_err
);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam logic [N-1:0] LAST_IDX   = '1;  // 2^N-1
   localparam logic [F-1:0] FLIGHT_MAX = '1;  // 2^F-1

   state_t           state_q;
   logic [N-1:0]     idx_q;         // index of the sample issued this cycle
   logic             p_en_q;
   logic [N-1:0]     p_cnt_q;
   logic [width-1:0] p_re_q;
   logic [width-1:0] p_im_q;
   logic             frame_done_q;
   logic [F-1:0]     in_flight_q;
   logic             err_q;

   logic             issue_d;       // a sample slot goes to the first stage
   logic             start_d;       // that slot is index 0, so p_en fires
   logic             underrun_d;    // slot inside a frame with no input sample
   logic             done_d;        // last stage emits its final index

   // Classify the current cycle: is a slot issued, does it start a frame,
   // is it an underrun?
   always_comb begin
      // NOTE: every output gets a default first so that no path infers a latch.
      issue_d    = 1'b0;
      start_d    = 1'b0;
      underrun_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (s_valid && run) begin
               issue_d = 1'b1;
               start_d = 1'b1;
            end
         end
         RUN: begin
            issue_d    = 1'b1;
            start_d    = (idx_q == '0);
            underrun_d = !s_valid;
         end
         default: ;
      endcase
   end

   assign done_d = q_en && (q_cnt == LAST_IDX);

   // s_ready is gated by areset, so it reads 0 while reset is asserted.
   assign s_ready = areset && ((state_q == RUN) || run);

   // Frame sequencer: the IDLE/RUN state, the slot index and the registered
   // first-stage outputs.
   always_ff @(posedge clk or negedge areset) begin
      if (!areset) begin
         state_q <= IDLE;
         idx_q   <= '0;
         p_en_q  <= 1'b0;
         p_cnt_q <= '0;
         p_re_q  <= '0;
         p_im_q  <= '0;
      end else begin
         // NOTE: all state is updated with non-blocking assignments, so every
         // right-hand side reads the value from before this clock edge.
         p_en_q  <= start_d;
         // idx_q is always 0 in IDLE, so p_cnt returns to 0 when nothing is issued.
         p_cnt_q <= idx_q;
         if (issue_d && s_valid) begin
            p_re_q <= s_re;
            p_im_q <= s_im;
         end else begin
            p_re_q <= '0;
            p_im_q <= '0;
         end
         unique case (state_q)
            IDLE: begin
               if (issue_d) begin
                  state_q <= RUN;
                  idx_q   <= N'(1);
               end
            end
            RUN: begin
               // The index wraps to 0 after 2^N-1, which gives a back-to-back
               // frame when run stays high.
               idx_q <= idx_q + N'(1);
               if ((idx_q == LAST_IDX) && !run) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Frame tracking: completion pulse, the saturating in-flight counter and
   // the sticky underrun flag. in_flight changes in the same cycle that the
   // matching p_en or frame_done pulse becomes visible.
   always_ff @(posedge clk or negedge areset) begin
      if (!areset) begin
         frame_done_q <= 1'b0;
         in_flight_q  <= '0;
         err_q        <= 1'b0;
      end else begin
         frame_done_q <= done_d;
         unique case ({start_d, done_d})
            2'b10: if (in_flight_q != FLIGHT_MAX) in_flight_q <= in_flight_q + F'(1);
            2'b01: if (in_flight_q != '0)         in_flight_q <= in_flight_q - F'(1);
            default: ;
         endcase
         // If clr_err and an underrun arrive in the same cycle, the underrun wins.
         if (underrun_d) begin
            err_q <= 1'b1;
         end else if (clr_err) begin
            err_q <= 1'b0;
         end
      end
   end

   assign p_en         = p_en_q;
   assign p_cnt        = p_cnt_q;
   assign p_re         = p_re_q;
   assign p_im         = p_im_q;
   assign frame_done   = frame_done_q;
   assign in_flight    = in_flight_q;
   assign err_underrun = err_q;
   assign busy         = (state_q != IDLE) || (in_flight_q != '0);

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Testbench for fft_frame_ctrl with N=3, F=4 and width=16. A frame-level
// reference model tracks whether a frame is open and the position within it,
// and predicts every output.
module tb_fft_frame_ctrl;

   localparam int W     = 16;
   localparam int NB    = 3;
   localparam int FB    = 4;
   localparam int FRAME = 1 << NB;
   localparam int FMAX  = (1 << FB) - 1;

   logic          clk = 1'b0;
   logic          areset;
   logic          run, s_valid, s_ready;
   logic [W-1:0]  s_re, s_im, p_re, p_im;
   logic          p_en;
   logic [NB-1:0] p_cnt, q_cnt;
   logic          q_en, frame_done, busy, err_underrun, clr_err;
   logic [FB-1:0] in_flight;

   int errors = 0;
   int checks = 0;

   // reference model state
   bit       m_active;
   int       m_pos;
   int       m_inflight;
   bit       m_err;
   bit       e_pen, e_fd;
   int       e_cnt;
   logic [W-1:0] e_re, e_im;

   fft_frame_ctrl #(.width(W), .N(NB), .F(FB)) dut (
      .clk(clk), .areset(areset), .run(run), .s_valid(s_valid), .s_ready(s_ready),
      .s_re(s_re), .s_im(s_im), .p_en(p_en), .p_cnt(p_cnt), .p_re(p_re), .p_im(p_im),
      .q_en(q_en), .q_cnt(q_cnt), .frame_done(frame_done), .in_flight(in_flight),
      .busy(busy), .err_underrun(err_underrun), .clr_err(clr_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_active = 0; m_pos = 0; m_inflight = 0; m_err = 0;
      e_pen = 0; e_fd = 0; e_cnt = 0; e_re = '0; e_im = '0;
   endtask

   task automatic drive(input bit r, input bit v, input logic [W-1:0] re,
                        input logic [W-1:0] im, input bit qe, input int qc, input bit clr);
      run = r; s_valid = v; s_re = re; s_im = im;
      q_en = qe; q_cnt = NB'(qc); clr_err = clr;
   endtask

   task automatic check_outputs();
      check("p_en", 32'(p_en), 32'(e_pen));
      check("p_cnt", 32'(p_cnt), 32'(e_cnt));
      check("p_re", 32'(p_re), 32'(e_re));
      check("p_im", 32'(p_im), 32'(e_im));
      check("frame_done", 32'(frame_done), 32'(e_fd));
      check("in_flight", 32'(in_flight), 32'(m_inflight));
      check("busy", 32'(busy), 32'(m_active || m_inflight != 0));
      check("err_underrun", 32'(err_underrun), 32'(m_err));
   endtask

   // One clock: predict from the current inputs, step, then compare.
   task automatic cycle();
      bit issue, start, done, under;
      #1;
      check("s_ready", 32'(s_ready), 32'(m_active || run));
      issue = m_active || (run && s_valid);
      under = m_active && !s_valid;
      start = issue && (m_pos == 0);
      done  = q_en && (int'(q_cnt) == FRAME - 1);
      e_pen = start;
      e_cnt = issue ? m_pos : 0;
      e_re  = (issue && s_valid) ? s_re : '0;
      e_im  = (issue && s_valid) ? s_im : '0;
      e_fd  = done;
      m_inflight = m_inflight + int'(start) - int'(done);
      if (m_inflight > FMAX) m_inflight = FMAX;
      if (m_inflight < 0) m_inflight = 0;
      if (under) m_err = 1;
      else if (clr_err) m_err = 0;
      if (issue) begin
         if (m_pos == FRAME - 1) begin
            m_pos = 0;
            m_active = run;  // continue back-to-back only while run is high
         end else begin
            m_pos++;
            m_active = 1;
         end
      end
      @(posedge clk);
      #1;
      check_outputs();
   endtask

   initial begin
      model_reset();
      areset = 1'b0;
      drive(1, 1, '0, '0, 0, 0, 0);
      #3;
      check("rst_s_ready", 32'(s_ready), 32'd0);
      check_outputs();
      #9 areset = 1'b1;

      // single frame: run dropped after the first accept, s_re=k, s_im=-k
      for (int k = 0; k < FRAME + 4; k++) begin
         drive(k == 0, 1, W'(k), W'(-k), 0, 0, 0);
         cycle();
      end

      // three back-to-back frames of data from $urandom
      for (int i = 0; i < 3 * FRAME; i++) begin
         drive(i < 3 * FRAME - 1, 1, W'($urandom), W'($urandom), 0, 0, 0);
         cycle();
      end
      check("b2b_in_flight", 32'(in_flight), 32'd4);

      // underrun at index 4, then clear the flag
      for (int i = 0; i < FRAME + 2; i++) begin
         drive(i < FRAME - 1, i != 4, W'($urandom), W'($urandom), 0, 0, 0);
         cycle();
      end
      check("underrun_sticky", 32'(err_underrun), 32'd1);
      drive(0, 0, '0, '0, 0, 0, 1);
      cycle();
      check("underrun_cleared", 32'(err_underrun), 32'd0);

      // underrun and clear in the same slot: set wins
      for (int i = 0; i < FRAME + 1; i++) begin
         drive(i < FRAME - 1, i != 2, W'($urandom), W'($urandom), 0, 0, i == 2);
         cycle();
      end

      // completion: drain every frame through q_cnt 0..7, with extra passes
      for (int f = 0; f < 7; f++) begin
         for (int c = 0; c < FRAME; c++) begin
            drive(0, 0, '0, '0, 1, c, 0);
            cycle();
         end
      end
      check("drained_busy", 32'(busy), 32'd0);

      // start and done in the same cycle with two frames in flight
      for (int i = 0; i < 3 * FRAME; i++) begin
         drive(i < 3 * FRAME - 1, 1, W'($urandom), W'($urandom), i == 2 * FRAME, FRAME - 1, 0);
         cycle();
         if (i == 2 * FRAME) check("simul_in_flight", 32'(in_flight), 32'd2);
      end

      // saturation at 2^F-1
      for (int i = 0; i < 18 * FRAME; i++) begin
         drive(i < 18 * FRAME - 1, 1, W'($urandom), W'($urandom), 0, 0, 0);
         cycle();
      end
      check("sat_in_flight", 32'(in_flight), 32'(FMAX));
      for (int i = 0; i < FMAX + 3; i++) begin
         drive(0, 0, '0, '0, 1, FRAME - 1, 0);
         cycle();
      end
      check("floor_in_flight", 32'(in_flight), 32'd0);

      // randomized traffic
      run = 0;
      for (int i = 0; i < 800; i++) begin
         bit r;
         r = ($urandom_range(0, 19) == 0) ? !run : run;
         drive(r, $urandom_range(0, 99) < 85, W'($urandom), W'($urandom),
               $urandom_range(0, 1) == 1,
               ($urandom_range(0, 1) == 1) ? FRAME - 1 : $urandom_range(0, FRAME - 1),
               $urandom_range(0, 19) == 0);
         cycle();
      end

      // asynchronous reset in the middle of a frame, at index 5
      for (int i = 0; i < FRAME + 5; i++) begin
         drive(1, 1, W'($urandom), W'($urandom), 0, 0, 0);
         cycle();
      end
      #2 areset = 1'b0;
      #1;
      model_reset();
      check("arst_s_ready", 32'(s_ready), 32'd0);
      check_outputs();
      @(posedge clk);
      #1 areset = 1'b1;
      #1;
      check("release_s_ready", 32'(s_ready), 32'(run));
      for (int i = 0; i < FRAME + 2; i++) begin
         drive(i == 0, 1, W'($urandom), W'($urandom), 0, 0, 0);
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
